// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: PC owner, per-cycle fetch into a prefetch queue, redirect/flush; FETCH_PERF_EN adds perf counters
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, FETCH, FULL, ERR} state_t;
    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic            err_q, err_d;
    logic [31:0]     pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];
    logic            push, pop, flush;
    assign imem_addr = pc_q;
    assign out_pc    = pc_mem[rd_q];
    assign out_inst  = inst_mem[rd_q];
    assign err       = err_q;
    assign out_valid = cnt_q != '0 && state_q != ERR;
    assign pop       = out_valid && out_ready;
    assign flush     = br_taken && state_q != ERR;
    assign push      = state_q == FETCH && en && !br_taken && (cnt_q != CW'(DEPTH) || pop);
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        err_d   = err_q;
        if (flush) begin
            cnt_d = '0;
            rd_d  = '0;
            wr_d  = '0;
            if (br_target[1:0] != 2'b00) begin
                state_d = ERR;
                err_d   = 1'b1;
            end else begin
                pc_d    = br_target;
                state_d = en ? FETCH : IDLE;
            end
        end else begin
            cnt_d = cnt_q + CW'(push) - CW'(pop);
            rd_d  = rd_q + AW'(pop);
            wr_d  = wr_q + AW'(push);
            pc_d  = push ? pc_q + 32'd4 : pc_q;
            case (state_q)
                IDLE:    state_d = en ? FETCH : IDLE;
                FETCH:   state_d = !en ? IDLE : (cnt_d == CW'(DEPTH) && !pop) ? FULL : FETCH;
                FULL:    state_d = !en ? IDLE : pop ? FETCH : FULL;
                default: state_d = state_q;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end
    // Queue storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_q]   <= pc_q;
            inst_mem[wr_q] <= imem_inst;
        end
    end
`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            fetch_cnt <= fetch_cnt + 32'(push);
            stall_cnt <= stall_cnt + 32'(state_q == FULL || (out_valid && !out_ready));
            flush_cnt <= flush_cnt + 16'(flush);
        end
    end
`endif
endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Instruction fetch controller that sequences the word-addressed instruction memory (combinational read, byte address in, 32-bit word out).
- Owns the PC, issues one fetch per cycle, and buffers fetched {pc, inst} pairs in a small prefetch queue.
- Hands instructions to decode over a valid/ready handshake.
- Handles branch redirects (queue flush) and misaligned-target errors.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
- DEPTH, 2, prefetch queue entries; power of two, 2..8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  fetch enable; sampled each cycle.
- imem_addr  out  32  byte address to instruction memory; equals PC register.
- imem_inst  in  32  instruction word returned combinationally for imem_addr.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts head.
- out_inst  out  32  head instruction.
- out_pc  out  32  head PC.
- br_taken  in  1  redirect request.
- br_target  in  32  redirect byte address.
- err  out  1  sticky misaligned-target error.

Behaviour:
- Reset, synchronous, dominant over all inputs:
  - pc=RESET_PC, queue count=0, rd/wr pointers=0, state=IDLE, err=0.
  - Outputs: out_valid=0, imem_addr=RESET_PC, out_inst/out_pc=head entry (don't care while out_valid=0).
  - Reset mid-operation discards queue contents the next cycle.
- FSM states IDLE, FETCH, FULL, ERR:
  - IDLE: no push. en=1 -> FETCH.
  - FETCH: en=0 -> IDLE. Queue becomes full after this edge with no pop -> FULL.
  - FULL: pop this cycle or br_taken -> FETCH. en=0 -> IDLE.
  - ERR: absorbing; only rst exits. No push, no pop effect, out_valid=0.
- Push condition: state==FETCH, en=1, br_taken=0, and (count<DEPTH or pop this cycle).
  - On push: write {pc, imem_inst} at wr pointer; pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
- Pop: out_valid && out_ready; advances rd pointer. Pop while out_valid=0 is ignored.
- Simultaneous push and pop: count unchanged, both pointers advance. Push at count==DEPTH is legal only with a simultaneous pop.
- out_valid = (count!=0). out_inst/out_pc are driven from the head entry with no combinational path from imem_inst.
- Latency:
  - en first sampled high in cycle N (state IDLE) -> FETCH in N+1, push at end of N+1, out_valid=1 in N+2 with out_pc=RESET_PC.
  - Steady-state throughput is 1 instruction/cycle when out_ready=1.
- Branch (br_taken=1, any state except ERR), highest priority after rst:
  - Queue flushed (count<=0, pointers<=0); no push that cycle; any pop that cycle is discarded.
  - br_target[1:0]==0: pc<=br_target; state<=FETCH if en=1, else IDLE. First target instruction valid 2 cycles after the br_taken cycle.
  - br_target[1:0]!=0: state<=ERR, err<=1, pc unchanged.
- en=0 with a non-empty queue: queue retained and still drains through pops.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds output fetch_cnt (32 bits): increments on each push.
  - Adds output stall_cnt (32 bits): increments each cycle in FULL, or each cycle out_valid=1 && out_ready=0.
  - Adds output flush_cnt (16 bits): increments on each br_taken accepted outside ERR.
  - All counters reset to 0 and wrap silently.
- Not defined: those ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Basic stream: rst 2 cycles, en=1, out_ready=1, memory words 0..6 preloaded -> out_pc 0,4,8,...,24 on consecutive cycles starting 2 cycles after en, out_inst matching each word; err=0.
- Backpressure: out_ready=0 for 6 cycles, DEPTH=2 -> count saturates at 2, state FULL, imem_addr holds 8. Release -> pcs 0,4,8 delivered with no gap, no loss, no duplicate.
- Branch flush: in steady state, br_taken=1, br_target=32'h10 -> next cycle out_valid=0, queued entries never delivered; 2 cycles later out_pc=32'h10.
- Misaligned branch: br_target=32'h6 -> err=1 next cycle, out_valid=0, held through 10 cycles of en=1; rst clears err and restarts at RESET_PC.
- Wrap and en gating: RESET_PC=32'hFFFF_FFF8 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000. en=0 mid-stream -> imem_addr frozen, queue drains; en=1 resumes at frozen pc.
- FETCH_PERF_EN build: 5 pushes, 3 stall cycles, 1 flush -> fetch_cnt=5, stall_cnt=3, flush_cnt=1; rst -> all 0.
